addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_if.sv | 33 +++
 rtl/addsub_seg.sv | 20 ++
 rtl/addsub_pipe.sv | 117 +++++++++++
 tb/tb_addsub_pipe.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared constants for the pipelined adder/subtractor.
// Defaults and flag bit positions used by the top level.
package addsub_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  localparam int NFLAGS    = 4;
  localparam int FLAG_COUT = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 3;

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_pipe.
// master drives operands and out_ready; slave is the adder.
interface addsub_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );

endinterface

// File: rtl/addsub_seg.sv
// One SEG-bit combinational slice of the ripple adder.
// cm is the carry into the slice MSB, used for overflow.
module addsub_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cm
);

  assign {co, s} = {1'b0, a} + {1'b0, b}
                 + {{SEG{1'b0}}, ci};

  // carry into the MSB falls out of the MSB sum bit
  assign cm = s[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: one SEG-bit slice per stage.
// Whole pipe advances together under a global stall.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic     clk,
  input logic     rst_n,
  addsub_if.slave bus
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  localparam logic [WIDTH-1:0] MASK =
    WIDTH'({SEG{1'b1}});

  if (WIDTH < 2 || STAGES < 1 ||
      WIDTH % STAGES != 0) begin : g_bad
    $error("addsub_pipe: WIDTH must split evenly");
  end

  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_d   [STAGES];

  logic [SEG-1:0]   seg_s [STAGES];
  logic [WIDTH-1:0] s_n   [STAGES];
  logic             c_n   [STAGES];
  logic             cm_n  [STAGES];

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             cm_q  [STAGES];

  logic              adv;
  logic [NFLAGS-1:0] flags;

  assign bus.out_valid = vld_q[LAST];
  assign bus.in_ready  = !bus.out_valid
                       || bus.out_ready;
  assign adv           = bus.in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_d[k] = bus.in_valid;
      assign a_d[k]   = bus.a;
      assign b_d[k]   = bus.sub ? ~bus.b : bus.b;
      assign s_d[k]   = '0;
      assign c_d[k]   = bus.sub ^ bus.cin;
    end else begin : g_link
      assign vld_d[k] = vld_q[k-1];
      assign a_d[k]   = a_q[k-1];
      assign b_d[k]   = b_q[k-1];
      assign s_d[k]   = s_q[k-1];
      assign c_d[k]   = c_q[k-1];
    end

    addsub_seg #(.SEG(SEG)) u_seg (
      .a  (a_d[k][k*SEG +: SEG]),
      .b  (b_d[k][k*SEG +: SEG]),
      .ci (c_d[k]),
      .s  (seg_s[k]),
      .co (c_n[k]),
      .cm (cm_n[k])
    );

    assign s_n[k] = (s_d[k] & ~(MASK << (k*SEG)))
                  | (WIDTH'(seg_s[k]) << (k*SEG));
  end

  // stage registers; bubbles keep their slot on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        cm_q[k]  <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_n[k];
        c_q[k]   <= c_n[k];
        cm_q[k]  <= cm_n[k];
      end
    end
  end

  // status flags from the final stage, gated by valid
  always_comb begin
    flags            = '0;
    flags[FLAG_COUT] = c_q[LAST];
    flags[FLAG_OVF]  = c_q[LAST] ^ cm_q[LAST];
    flags[FLAG_ZERO] = ~|s_q[LAST];
    flags[FLAG_NEG]  = s_q[LAST][WIDTH-1];
    if (!vld_q[LAST]) flags = '0;
  end

  assign bus.sum  = s_q[LAST];
  assign bus.cout = flags[FLAG_COUT];
  assign bus.ovf  = flags[FLAG_OVF];
  assign bus.zero = flags[FLAG_ZERO];
  assign bus.neg  = flags[FLAG_NEG];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed vectors, queue scoreboard.
// Second instance covers the WIDTH=8, STAGES=1 corner.
module tb_addsub_pipe;

  typedef struct {
    logic [15:0] sum;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t q[$];
  exp_t e;

  addsub_if #(.WIDTH(16)) bus16 ();
  addsub_if #(.WIDTH(8))  bus8 ();

  addsub_pipe #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  addsub_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic s,
                       input logic ci,
                       input logic [15:0] es,
                       input logic ec,
                       input logic ev,
                       input logic ez,
                       input logic en,
                       input bit lat);
    int   n;
    bit   acc;
    exp_t x;
    n   = 0;
    acc = 0;
    bus16.a        = a;
    bus16.b        = b;
    bus16.sub      = s;
    bus16.cin      = ci;
    bus16.in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (bus16.in_ready) begin
        acc   = 1;
        x.sum = es;
        x.c   = ec;
        x.v   = ev;
        x.z   = ez;
        x.n   = en;
        x.acc = cyc;
        x.lat = lat;
        q.push_back(x);
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus16.in_valid = 1'b0;
    if (!acc) chk("accept timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: pop on take, check hold on stall
  always @(negedge clk) begin
    if (rst_n && bus16.out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected result",
            32'(bus16.out_valid), 32'd0);
      end else if (bus16.out_ready) begin
        e = q.pop_front();
        chk("sum",  32'(bus16.sum),  32'(e.sum));
        chk("cout", 32'(bus16.cout), 32'(e.c));
        chk("ovf",  32'(bus16.ovf),  32'(e.v));
        chk("zero", 32'(bus16.zero), 32'(e.z));
        chk("neg",  32'(bus16.neg),  32'(e.n));
        if (e.lat)
          chk("latency", 32'(cyc - e.acc), 32'd4);
      end else begin
        chk("stall in_ready",
            32'(bus16.in_ready), 32'd0);
        chk("stall hold sum",
            32'(bus16.sum), 32'(q[0].sum));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc8;
    n_tests         = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.sub       = 1'b0;
    bus16.cin       = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.out_ready  = 1'b1;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.sub        = 1'b0;
    bus8.cin        = 1'b0;

    #2;
    chk("rst out_valid", 32'(bus16.out_valid), 0);
    chk("rst in_ready",  32'(bus16.in_ready),  1);
    chk("rst sum",       32'(bus16.sum),       0);
    chk("rst cout",      32'(bus16.cout),      0);
    chk("rst ovf",       32'(bus16.ovf),       0);
    chk("rst zero",      32'(bus16.zero),      0);
    chk("rst neg",       32'(bus16.neg),       0);
    chk("rst8 out_valid", 32'(bus8.out_valid), 0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // isolated vectors with latency checks
    issue(16'hFFFF, 16'h0001, 0, 0,
          16'h0000, 1, 0, 1, 0, 1);
    drain();
    issue(16'h7FFF, 16'h0001, 0, 0,
          16'h8000, 0, 1, 0, 1, 1);
    drain();
    issue(16'h0005, 16'h0007, 1, 0,
          16'hFFFE, 0, 0, 0, 1, 1);
    drain();

    // six back-to-back with a mid-stream stall
    fork
      begin
        issue(16'h0001, 16'h0002, 0, 0,
              16'h0003, 0, 0, 0, 0, 0);
        issue(16'h1000, 16'h0FFF, 0, 1,
              16'h2000, 0, 0, 0, 0, 0);
        issue(16'h8000, 16'h0001, 1, 0,
              16'h7FFF, 1, 1, 0, 0, 0);
        issue(16'h1234, 16'h1234, 1, 0,
              16'h0000, 1, 0, 1, 0, 0);
        issue(16'hABCD, 16'h1111, 0, 0,
              16'hBCDE, 0, 0, 0, 1, 0);
        issue(16'h0000, 16'h0000, 1, 1,
              16'hFFFF, 0, 0, 0, 1, 0);
      end
      begin
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        bus16.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus16.out_ready = 1'b1;
      end
    join
    drain();

    // reset with three transactions in flight
    issue(16'h1111, 16'h1111, 0, 0,
          16'h2222, 0, 0, 0, 0, 0);
    issue(16'h2222, 16'h2222, 0, 0,
          16'h4444, 0, 0, 0, 0, 0);
    issue(16'h3333, 16'h3333, 0, 0,
          16'h6666, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", 32'(bus16.out_valid), 0);
    chk("mid-rst in_ready",  32'(bus16.in_ready),  1);
    chk("mid-rst sum",       32'(bus16.sum),       0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(16'h1234, 16'h1111, 0, 0,
          16'h2345, 0, 0, 0, 0, 1);
    drain();

    // single-stage 8-bit instance
    bus8.a        = 8'h80;
    bus8.b        = 8'h01;
    bus8.sub      = 1'b1;
    bus8.cin      = 1'b1;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    acc8 = cyc;
    chk("w8 in_ready", 32'(bus8.in_ready), 1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    chk("w8 out_valid", 32'(bus8.out_valid), 1);
    chk("w8 latency",   32'(cyc - acc8),     1);
    chk("w8 sum",       32'(bus8.sum),       32'h7E);
    chk("w8 ovf",       32'(bus8.ovf),       1);
    chk("w8 cout",      32'(bus8.cout),      1);
    chk("w8 zero",      32'(bus8.zero),      0);
    chk("w8 neg",       32'(bus8.neg),       0);
    @(negedge clk);
    chk("w8 out_valid drop", 32'(bus8.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
